// File: rtl/instr_sequencer_pkg.sv
// Shared types for the instruction sequencer: instruction/register words,
// FSM state encoding and fault cause codes.
package instr_sequencer_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef logic [XLEN_DEFAULT-1:0] instruction_t;
    typedef logic [XLEN_DEFAULT-1:0] register_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH_REQ,
        S_FETCH_WAIT,
        S_DECODE,
        S_EXECUTE,
        S_WRITEBACK,
        S_HALT
    } seq_state_t;

    typedef enum logic [1:0] {
        FAULT_NONE     = 2'd0,
        FAULT_ILLEGAL  = 2'd1,
        FAULT_TIMEOUT  = 2'd2,
        FAULT_MISALIGN = 2'd3
    } fault_cause_t;

endpackage

// File: rtl/instr_sequencer_timeout_ctr.sv
// Fetch timeout counter: cleared on entry to FETCH_REQ, counts cycles spent
// in the fetch states and saturates once the budget is used up.
module seq_timeout_ctr #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    localparam int W = $clog2(MEM_TIMEOUT + 1);
    // The count is 0 in the first fetch cycle, so the cycle holding
    // MEM_TIMEOUT-1 is the MEM_TIMEOUT-th fetch cycle.
    localparam logic [W-1:0] LIMIT = W'(MEM_TIMEOUT - 1);

    logic [W-1:0] count;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != LIMIT)) begin
            count <= count + W'(1);
        end
    end

    assign expired = (count == LIMIT);

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback sequencer with fetch handshake,
// instruction latch and fault reporting. Optional macro: MISALIGN_TRAP_EN.
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int XLEN        = XLEN_DEFAULT,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            run,
    input  logic [XLEN-1:0] pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            stall,
    output logic [XLEN-1:0] instr_out,
    output logic            decode_en,
    output logic            exec_en,
    output logic            wb_en,
    output logic            retired,
    output logic            halted,
    output logic [1:0]      fault_cause
);

    seq_state_t   state_q, state_d;
    fault_cause_t cause_q, cause_d;
    logic [XLEN-1:0] instr_q;
    logic ctr_clr, ctr_inc, expired, misaligned, illegal;

`ifdef MISALIGN_TRAP_EN
    assign misaligned = (pc[1:0] != 2'b00);
    assign imem_addr  = pc;
`else
    assign misaligned = 1'b0;
    assign imem_addr  = pc & ~XLEN'(3);
`endif

    assign illegal = (instr_q[1:0] != 2'b11) || (instr_q == '0) || (&instr_q);

    seq_timeout_ctr #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clr     (ctr_clr),
        .inc     (ctr_inc),
        .expired (expired)
    );

    // NOTE: every output of this block gets a default before the case so
    // no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        cause_d   = cause_q;
        imem_req  = 1'b0;
        decode_en = 1'b0;
        exec_en   = 1'b0;
        wb_en     = 1'b0;
        retired   = 1'b0;
        halted    = 1'b0;
        ctr_inc   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH_REQ;
            end
            S_FETCH_REQ: begin
                ctr_inc = 1'b1;
                if (misaligned) begin
                    state_d = S_HALT;
                    cause_d = FAULT_MISALIGN;
                end else begin
                    imem_req = 1'b1;
                    // A grant in the expiry cycle still wins over the timeout.
                    if (imem_gnt) begin
                        state_d = S_FETCH_WAIT;
                    end else if (expired) begin
                        state_d = S_HALT;
                        cause_d = FAULT_TIMEOUT;
                    end
                end
            end
            S_FETCH_WAIT: begin
                ctr_inc = 1'b1;
                if (imem_rvalid) begin
                    state_d = S_DECODE;
                end else if (expired) begin
                    state_d = S_HALT;
                    cause_d = FAULT_TIMEOUT;
                end
            end
            S_DECODE: begin
                decode_en = 1'b1;
                if (illegal) begin
                    state_d = S_HALT;
                    cause_d = FAULT_ILLEGAL;
                end else begin
                    state_d = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                // The branch unit advances the PC on every enable, so this
                // fires exactly once per instruction.
                if (!stall) begin
                    exec_en = 1'b1;
                    state_d = S_WRITEBACK;
                end
            end
            S_WRITEBACK: begin
                wb_en   = 1'b1;
                retired = 1'b1;
                state_d = run ? S_FETCH_REQ : S_IDLE;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign ctr_clr = (state_d == S_FETCH_REQ) && (state_q != S_FETCH_REQ);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cause_q <= FAULT_NONE;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            if ((state_q == S_FETCH_WAIT) && imem_rvalid) instr_q <= imem_rdata;
        end
    end

    assign instr_out   = instr_q;
    assign fault_cause = cause_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: directed programs push expected
// retire/halt events; a monitor pops and compares them as the DUT reports.
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        rst, run, imem_req, imem_gnt, imem_rvalid, stall;
    logic [31:0] pc, imem_addr, imem_rdata, instr_out;
    logic        decode_en, exec_en, wb_en, retired, halted;
    logic [1:0]  fault_cause;

    typedef struct {
        bit          is_halt;
        logic [31:0] instr;
        logic [1:0]  cause;
        int          period;
    } exp_t;

    exp_t sb[$];
    int pass_cnt = 0;
    int total_cnt = 0;

    bit          mem_auto = 1'b1;
    bit          gnt_en = 1'b1;
    int          gnt_delay = 0;
    int          rvalid_delay = 0;
    int          stall_cfg = 0;
    logic [31:0] mem_word = 32'h0000_0013;

    always #5 clk = ~clk;

    instr_sequencer #(.XLEN(32), .MEM_TIMEOUT(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .pc          (pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .instr_out   (instr_out),
        .decode_en   (decode_en),
        .exec_en     (exec_en),
        .wb_en       (wb_en),
        .retired     (retired),
        .halted      (halted),
        .fault_cause (fault_cause)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    function automatic void expect_retire(input logic [31:0] instr, input int period);
        sb.push_back('{1'b0, instr, 2'd0, period});
    endfunction

    function automatic void expect_halt(input logic [1:0] cause);
        sb.push_back('{1'b1, 32'h0, cause, 0});
    endfunction

    // Memory, stall source and branch-unit model; drives just after posedge.
    initial begin : responder
        bit ex_seen, dec_seen, pending;
        int req_cnt, wait_cnt, stall_left;
        pending = 0; req_cnt = 0; wait_cnt = 0; stall_left = 0;
        imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0; stall = 0;
        forever begin
            @(negedge clk);
            ex_seen  = exec_en;
            dec_seen = decode_en;
            @(posedge clk);
            #1;
            if (rst) begin
                pending = 0; req_cnt = 0; wait_cnt = 0; stall_left = 0;
            end
            if (mem_auto) begin
                imem_gnt    = 0;
                imem_rvalid = 0;
                if (rst) begin
                    stall = 0;
                end else begin
                    if (ex_seen) pc = pc + 32'd4;
                    if (dec_seen) stall_left = stall_cfg;
                    if (stall_left > 0) begin
                        stall = 1; stall_left--;
                    end else begin
                        stall = 0;
                    end
                    if (pending) begin
                        if (wait_cnt == rvalid_delay) begin
                            imem_rvalid = 1; imem_rdata = mem_word; pending = 0;
                        end else begin
                            wait_cnt++;
                        end
                    end
                    if (imem_req) begin
                        if (gnt_en && req_cnt == gnt_delay) begin
                            imem_gnt = 1; pending = 1; wait_cnt = 0; req_cnt = 0;
                        end else begin
                            req_cnt++;
                        end
                    end else begin
                        req_cnt = 0;
                    end
                end
            end
        end
    end

    initial begin : monitor
        int   cyc, last_ret, exec_cnt;
        bit   prev_halted;
        exp_t e;
        cyc = 0; last_ret = -1; exec_cnt = 0; prev_halted = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                exec_cnt = 0; last_ret = -1; prev_halted = 0;
                continue;
            end
            if (exec_en) exec_cnt++;
            if (retired || (halted && !prev_halted)) begin
                if (sb.size() == 0) begin
                    total_cnt++;
                    $display("FAIL sb_unexpected: %s event with nothing expected",
                             retired ? "retire" : "halt");
                end else begin
                    e = sb.pop_front();
                    check("ev_kind", {31'b0, halted}, {31'b0, e.is_halt});
                    if (e.is_halt) check("ev_cause", {30'b0, fault_cause}, {30'b0, e.cause});
                    else           check("ev_instr", instr_out, e.instr);
                    check("ev_exec_count", exec_cnt, e.is_halt ? 0 : 1);
                    if (!e.is_halt && e.period != 0) check("ev_period", cyc - last_ret, e.period);
                end
                exec_cnt = 0;
                if (retired) last_ret = cyc;
            end
            prev_halted = halted;
        end
    end

    task automatic run_instrs(input int n, output logic [31:0] first_addr, output int req_cycles);
        int k;
        bit seen;
        k = 0; seen = 0; req_cycles = 0; first_addr = 'x;
        run = 1;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (imem_req) begin
                req_cycles++;
                if (!seen) begin first_addr = imem_addr; seen = 1; end
            end
            if (decode_en) k++;
            if (k >= n || halted) break;
        end
        run = 0;
        if (k < n && !halted) check("run_budget", k, n);
    endtask

    task automatic wait_drain(input string tag);
        for (int c = 0; c < 60 && sb.size() != 0; c++) @(negedge clk);
        @(negedge clk);
        check({"sb_drain_", tag}, sb.size(), 0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1;
        repeat (2) @(negedge clk);
        rst = 0;
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic [31:0] addr;
        int reqs, cnt;
        rst = 1; run = 0; pc = 32'h0000_1000;
        repeat (2) @(negedge clk);
        check("rst_imem_req", {31'b0, imem_req}, 0);
        check("rst_strobes", {28'b0, decode_en, exec_en, wb_en, retired}, 0);
        check("rst_halted", {31'b0, halted}, 0);
        check("rst_fault", {30'b0, fault_cause}, 0);
        check("rst_instr", instr_out, 0);
        check("rst_imem_addr", imem_addr, 32'h0000_1000);
        rst = 0;

        // Back-to-back minimal-latency instructions: period 5.
        mem_word = 32'h0000_0013;
        expect_retire(32'h0000_0013, 0);
        expect_retire(32'h0000_0013, 5);
        expect_retire(32'h0000_0013, 5);
        run_instrs(3, addr, reqs);
        check("normal_first_addr", addr, 32'h0000_1000);
        wait_drain("normal");

        // Three stall cycles in EXECUTE stretch the period to 8.
        stall_cfg = 3;
        mem_word  = 32'h0020_8033;
        expect_retire(32'h0020_8033, 0);
        expect_retire(32'h0020_8033, 8);
        run_instrs(2, addr, reqs);
        wait_drain("stall");
        stall_cfg = 0;

        // run dropped during WRITEBACK: FSM returns to IDLE.
        pc = 32'h0000_1800; mem_word = 32'h0050_0093;
        expect_retire(32'h0050_0093, 0);
        run = 1;
        for (int c = 0; c < 30 && !wb_en; c++) @(negedge clk);
        run = 0;
        cnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (imem_req || decode_en) cnt++;
        end
        check("wb_run_low_idle", cnt, 0);
        wait_drain("wb");

        // Misaligned PC.
        pc = 32'h0000_0102; mem_word = 32'h00a0_0113;
`ifdef MISALIGN_TRAP_EN
        expect_halt(2'd3);
        run_instrs(1, addr, reqs);
        check("mis_req_cycles", reqs, 0);
        wait_drain("misalign");
        apply_reset();
`else
        expect_retire(32'h00a0_0113, 0);
        run_instrs(1, addr, reqs);
        check("mis_aligned_addr", addr, 32'h0000_0100);
        wait_drain("misalign");
`endif

        // Reset during FETCH_WAIT, then a stray rvalid in IDLE and FETCH_REQ.
        pc = 32'h0000_2000; mem_word = 32'h0000_0013; rvalid_delay = 3;
        run = 1;
        for (int c = 0; c < 20 && !imem_req; c++) @(negedge clk);
        @(negedge clk);
        rst = 1;
        #1;
        check("rstw_imem_req", {31'b0, imem_req}, 0);
        check("rstw_instr", instr_out, 0);
        check("rstw_strobes", {27'b0, decode_en, exec_en, wb_en, retired, halted}, 0);
        mem_auto = 0; run = 0;
        imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'hdead_beef;
        @(negedge clk);
        rst = 0;
        cnt = 0;
        repeat (2) begin @(negedge clk); if (decode_en || imem_req) cnt++; end
        check("late_rvalid_idle", cnt, 0);
        run = 1;
        repeat (2) begin @(negedge clk); if (decode_en) cnt++; end
        check("late_rvalid_req", {31'b0, imem_req}, 1);
        check("late_rvalid_decode", cnt, 0);
        check("late_rvalid_instr", instr_out, 0);
        rst = 1; run = 0; imem_rvalid = 0; mem_auto = 1; rvalid_delay = 0;
        repeat (2) @(negedge clk);
        rst = 0;

        // Illegal all-zero instruction: sticky halt.
        pc = 32'h0000_3000; mem_word = 32'h0000_0000;
        expect_halt(2'd1);
        run_instrs(1, addr, reqs);
        wait_drain("illegal");
        cnt = 0;
        for (int c = 0; c < 6; c++) begin
            run = c[0];
            @(negedge clk);
            if (!halted || imem_req || decode_en || exec_en) cnt++;
        end
        run = 0;
        check("illegal_sticky", cnt, 0);
        check("illegal_cause_held", {30'b0, fault_cause}, 1);
        apply_reset();

        // Grant never arrives: timeout after 4 FETCH_REQ cycles.
        pc = 32'h0000_4000; mem_word = 32'h0000_0013; gnt_en = 0;
        expect_halt(2'd2);
        run_instrs(1, addr, reqs);
        check("timeout_req_cycles", reqs, 4);
        wait_drain("timeout");
        apply_reset();
        gnt_en = 1;

        // Grant on the 4th request cycle wins over the timeout.
        gnt_delay = 3;
        expect_retire(32'h0000_0013, 0);
        run_instrs(1, addr, reqs);
        check("late_gnt_req_cycles", reqs, 4);
        wait_drain("late_gnt");
        check("late_gnt_no_halt", {29'b0, halted, fault_cause}, 0);
        gnt_delay = 0;

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Multi-cycle instruction sequencer that drives the core through fetch, decode, execute and writeback for one instruction at a time. It owns the instruction-memory request handshake and latches the fetched word. It generates the single-cycle execute enable consumed by the branch unit, which advances the PC. Sits between the instruction-memory port and the decode/branch/register-file datapath, and reports halt and fault status to the top level.

## Interface
- XLEN, 32, datapath and address width
- MEM_TIMEOUT, 255, maximum cycles spent in the fetch states before a timeout fault; legal range 2..65535
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- run  in  1  level; sequencer starts and continues fetching while high
- pc  in  XLEN  current PC from the branch unit
- imem_req  out  1  instruction fetch request
- imem_addr  out  XLEN  fetch address
- imem_gnt  in  1  request accepted
- imem_rvalid  in  1  fetch data valid
- imem_rdata  in  XLEN  fetched instruction word
- stall  in  1  execute-stage hold from the datapath
- instr_out  out  XLEN  latched instruction (instruction_t)
- decode_en  out  1  decode strobe
- exec_en  out  1  execute strobe, routed to the branch unit enable
- wb_en  out  1  register-file writeback strobe
- retired  out  1  one-cycle pulse per completed instruction
- halted  out  1  sequencer is in HALT
- fault_cause  out  2  0 NONE, 1 ILLEGAL, 2 TIMEOUT, 3 MISALIGN

## Operation
- FSM states: IDLE, FETCH_REQ, FETCH_WAIT, DECODE, EXECUTE, WRITEBACK, HALT.
- **IDLE**
  - All strobes are low.
  - When run=1, go to FETCH_REQ.
- **FETCH_REQ**
  - imem_req=1, imem_addr=pc.
  - On imem_gnt, go to FETCH_WAIT.
  - Any imem_rvalid seen in this state is ignored.
- **FETCH_WAIT**
  - imem_req=0.
  - On imem_rvalid, latch imem_rdata into instr_out and go to DECODE.
- **Fetch timeout**
  - The timeout counter clears on entry to FETCH_REQ and increments every cycle spent in FETCH_REQ or FETCH_WAIT.
  - If the count reaches MEM_TIMEOUT in a cycle where the state would not otherwise advance, go to HALT with cause TIMEOUT.
  - If imem_gnt or imem_rvalid arrives in that same cycle, the handshake wins.
- **DECODE**
  - decode_en=1 for one cycle, then go to EXECUTE.
  - If instr_out[1:0]!=2'b11, or instr_out is all-zeros or all-ones, go to HALT with cause ILLEGAL instead. decode_en is still asserted in that cycle.
- **EXECUTE**
  - While stall=1: exec_en=0 and the state holds.
  - First cycle with stall=0: exec_en=1, then go to WRITEBACK.
  - exec_en is asserted exactly once per instruction, because the branch unit updates the PC on every enable.
- **WRITEBACK**
  - wb_en=1 and retired=1 for one cycle.
  - If run=1, go to FETCH_REQ; otherwise go to IDLE.
- **HALT**
  - halted=1 and fault_cause holds its value.
  - All strobes and imem_req are 0.
  - Exit only through rst.
- Deasserting run mid-instruction does not abort; the current instruction completes through WRITEBACK and the FSM then goes to IDLE.
- Strobes and imem_req/imem_addr are decoded from the registered state (Moore outputs). exec_en also gates on stall.

## Timing
- **Reset values** (asynchronous): state IDLE; instr_out 0; fault_cause 0; timeout counter 0; every strobe, imem_req, halted and retired 0. imem_addr=pc is combinational.
- **Minimum instruction period**: 5 cycles (gnt in the first REQ cycle, rvalid in the first WAIT cycle, no stall). Each wait or stall cycle adds one.
- **PC update**: the branch unit updates the PC at the edge ending the exec_en cycle. The next FETCH_REQ, two cycles later, sees the updated pc.
- **Reset mid-fetch**: imem_req drops asynchronously. A late rvalid arriving in IDLE or FETCH_REQ is ignored.

## Configuration
- MISALIGN_TRAP_EN defined:
  - In FETCH_REQ, if pc[1:0]!=0, go directly to HALT with cause MISALIGN.
  - imem_req is never asserted for that address.
- MISALIGN_TRAP_EN undefined:
  - imem_addr = {pc[XLEN-1:2],2'b00}.
  - Cause 3 is never produced.

## Structure
- **opcodes package**: add seq_state_t (enum of the seven states) and fault_cause_t (2-bit enum). instruction_t and register_t come from the same package.
- **Sub-module seq_timeout_ctr**: holds the parameterised counter with inputs clr/inc and output expired; width is $clog2(MEM_TIMEOUT+1).
- The FSM and instruction latch stay in instr_sequencer.

## Test plan
- run=1, gnt same cycle as req, rvalid next cycle, rdata=0x00000013, stall=0: retired pulses every 5 cycles; exec_en high exactly 1 cycle per instruction.
- stall=1 for 3 cycles in EXECUTE: exec_en stays 0 for 3 cycles, then pulses once; instruction period is 8 cycles.
- imem_rdata=0x00000000: decode_en pulses, next cycle halted=1 and fault_cause=1; no exec_en; run toggling has no effect until rst.
- MEM_TIMEOUT=4, gnt never asserted: halted=1 and fault_cause=2 after 4 cycles in FETCH_REQ. Repeat with gnt arriving on the 4th cycle: reaches FETCH_WAIT with no fault.
- With MISALIGN_TRAP_EN, pc=0x102: imem_req never high, fault_cause=3. Without the macro: imem_addr=0x100 and the instruction executes normally.
- rst asserted during FETCH_WAIT, then rvalid pulses: outputs return to reset values immediately and the rvalid is ignored; run=0 during WRITEBACK → FSM goes to IDLE with imem_req=0.
